shift_sequencer: RTL and testbench

- Control sequencer for the 8-bit shift register block, whose pins are serial_in, parallel_in, Load, clear, shift and out.
- Drives that register's control pins to run framed serial transfers: TX loads a byte and shifts it out MSB-first; RX clears the register and shifts in WIDTH bits from a serial line.
- Bit period is a programmable number of clocks. A start/ready/done handshake faces the host logic.

---
 rtl/shift_seq_pkg.sv | 20 ++
 rtl/shift_sequencer_if.sv | 25 ++
 rtl/shift_sequencer_bit_timer.sv | 46 ++++
 rtl/shift_sequencer.sv | 115 +++++++++++
 tb/tb_shift_sequencer.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift register sequencer.
// Includes the state encoding, the transfer mode constants and a counter width helper.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PREP  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic MODE_TX = 1'b0;
    localparam logic MODE_RX = 1'b1;

    // A divide-by-one timer still needs a 1-bit counter so the strobe compare stays legal.
    function automatic int div_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Host-side start/ready/done handshake of the shift register sequencer.
// The host drives the master modport and the sequencer uses the slave modport.
interface shift_sequencer_if #(
    parameter int WIDTH = 8
) ();

    logic             start;
    logic             mode;
    logic [WIDTH-1:0] data_in;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] data_out;

    modport master (
        output start, mode, data_in,
        input  ready, busy, done, data_out
    );

    modport slave (
        input  start, mode, data_in,
        output ready, busy, done, data_out
    );

endinterface

// File: rtl/shift_sequencer_bit_timer.sv
// Bit-period timer: div_cnt paces one strobe every DIV clocks and bit_cnt counts strobes.
// last_bit flags the final bit of a transfer, so the strobe in that bit ends the transfer.
module bit_timer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 4,
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic clear,
    input  logic run,
    input  logic restart,
    output logic strobe,
    output logic last_bit
);

    localparam int DIV_W = div_width(DIV);

    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] bit_cnt;

    assign strobe   = run && (div_cnt == DIV_W'(DIV - 1));
    assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));

    // bit_cnt stops at WIDTH-1 so it cannot wrap if run is held past the final strobe.
    always_ff @(posedge clk) begin
        if (!clear) begin
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (restart) begin
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (run) begin
            if (strobe) begin
                div_cnt <= '0;
                if (!last_bit) begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Sequencer that drives the control pins of an 8-bit shift register.
// TX loads a byte and shifts it out MSB-first; RX clears the register and shifts in WIDTH bits.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clear,
    shift_sequencer_if.slave host,
    input  logic             serial_rx,
    output logic             serial_tx,
    output logic             sr_load,
    output logic             sr_shift,
    output logic             sr_clear_n,
    output logic [WIDTH-1:0] sr_parallel,
    output logic             sr_serial_in,
    input  logic [WIDTH-1:0] sr_q
);

    state_t           state;
    state_t           next_state;
    logic             mode_q;
    logic [WIDTH-1:0] byte_q;
    logic             clear_n_q;
    logic             run;
    logic             restart;
    logic             strobe;
    logic             last_bit;

    bit_timer #(
        .WIDTH (WIDTH),
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_bit_timer (
        .clk      (clk),
        .clear    (clear),
        .run      (run),
        .restart  (restart),
        .strobe   (strobe),
        .last_bit (last_bit)
    );

    // clear_n_q is registered so it sits low for exactly the RX PREP cycle.
    always_ff @(posedge clk) begin
        if (!clear) begin
            state     <= IDLE;
            mode_q    <= MODE_TX;
            byte_q    <= '0;
            clear_n_q <= 1'b0;
        end else begin
            state     <= next_state;
            clear_n_q <= !((state == IDLE) && host.start && (host.mode == MODE_RX));
            if ((state == IDLE) && host.start) begin
                mode_q <= host.mode;
                byte_q <= host.data_in;
            end
        end
    end

    always_comb begin
        next_state   = state;
        run          = 1'b0;
        restart      = 1'b0;
        sr_load      = 1'b0;
        sr_shift     = 1'b0;
        sr_serial_in = 1'b0;
        serial_tx    = 1'b1;
        host.ready   = 1'b0;
        host.busy    = 1'b0;
        host.done    = 1'b0;
        case (state)
            IDLE: begin
                host.ready = 1'b1;
                if (host.start) begin
                    next_state = PREP;
                end
            end
            PREP: begin
                host.busy = 1'b1;
                restart   = 1'b1;
                if (mode_q == MODE_TX) begin
                    sr_load  = 1'b1;
                    sr_shift = 1'b1;
                end
                next_state = SHIFT;
            end
            SHIFT: begin
                host.busy = 1'b1;
                run       = 1'b1;
                sr_shift  = strobe;
                if (mode_q == MODE_TX) begin
                    serial_tx = sr_q[WIDTH-1];
                end else begin
                    sr_serial_in = serial_rx;
                end
                if (strobe && last_bit) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                host.done  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign sr_clear_n    = clear_n_q;
    assign sr_parallel   = byte_q;
    assign host.data_out = sr_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench: a DIV=2 sequencer and a DIV=1 sequencer, each driving a shift register model.
// Expected values are hand-derived from the transfer timing, with start sampled at the edge that ends cycle 0.
module tb_shift_sequencer;
    import shift_seq_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic clear = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    shift_sequencer_if #(.WIDTH(W)) host_a ();
    shift_sequencer_if #(.WIDTH(W)) host_b ();

    logic         rx_a, tx_a, load_a, shift_a, clr_n_a, sin_a;
    logic [W-1:0] par_a, q_a;
    logic         rx_b, tx_b, load_b, shift_b, clr_n_b, sin_b;
    logic [W-1:0] par_b, q_b;

    shift_sequencer #(.WIDTH(W), .DIV(2), .CNT_W(4)) dut_a (
        .clk          (clk),
        .clear        (clear),
        .host         (host_a),
        .serial_rx    (rx_a),
        .serial_tx    (tx_a),
        .sr_load      (load_a),
        .sr_shift     (shift_a),
        .sr_clear_n   (clr_n_a),
        .sr_parallel  (par_a),
        .sr_serial_in (sin_a),
        .sr_q         (q_a)
    );

    shift_sequencer #(.WIDTH(W), .DIV(1), .CNT_W(4)) dut_b (
        .clk          (clk),
        .clear        (clear),
        .host         (host_b),
        .serial_rx    (rx_b),
        .serial_tx    (tx_b),
        .sr_load      (load_b),
        .sr_shift     (shift_b),
        .sr_clear_n   (clr_n_b),
        .sr_parallel  (par_b),
        .sr_serial_in (sin_b),
        .sr_q         (q_b)
    );

    // Shift register model: asynchronous active-low clear, and Load only acts together with shift.
    always_ff @(posedge clk or negedge clr_n_a) begin
        if (!clr_n_a)     q_a <= '0;
        else if (shift_a) q_a <= load_a ? par_a : {q_a[W-2:0], sin_a};
    end

    always_ff @(posedge clk or negedge clr_n_b) begin
        if (!clr_n_b)     q_b <= '0;
        else if (shift_b) q_b <= load_b ? par_b : {q_b[W-2:0], sin_b};
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] tx_pat;
        logic [W-1:0] rx_bits;

        host_a.start = 1'b0; host_a.mode = MODE_TX; host_a.data_in = '0;
        host_b.start = 1'b0; host_b.mode = MODE_TX; host_b.data_in = '0;
        rx_a = 1'b0; rx_b = 1'b0;

        // Reset held for three cycles, then released.
        clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("rst_ready", 32'(host_a.ready), 32'd1);
            check_output("rst_tx", 32'(tx_a), 32'd1);
            check_output("rst_clr_n", 32'(clr_n_a), 32'd0);
            check_output("rst_busy", 32'(host_a.busy), 32'd0);
        end
        clear = 1'b1;
        tick();
        check_output("rel_clr_n_a", 32'(clr_n_a), 32'd1);
        check_output("rel_clr_n_b", 32'(clr_n_b), 32'd1);
        check_output("rel_q_a", 32'(q_a), 32'd0);
        check_output("rel_ready_b", 32'(host_b.ready), 32'd1);

        // TX of 8'hA5 at DIV=2.
        tx_pat = 8'hA5;
        host_a.mode = MODE_TX; host_a.data_in = tx_pat; host_a.start = 1'b1;
        tick();
        host_a.start = 1'b0;
        check_output("tx_prep_busy", 32'(host_a.busy), 32'd1);
        check_output("tx_prep_ready", 32'(host_a.ready), 32'd0);
        check_output("tx_prep_load", 32'({load_a, shift_a}), 32'd3);
        for (int c = 2; c <= 17; c++) begin
            tick();
            check_output($sformatf("tx_bit_c%0d", c), 32'(tx_a), 32'(tx_pat[7 - (c - 2) / 2]));
            check_output($sformatf("tx_nodone_c%0d", c), 32'(host_a.done), 32'd0);
        end
        tick();
        check_output("tx_done", 32'(host_a.done), 32'd1);
        check_output("tx_done_ready", 32'(host_a.ready), 32'd0);
        check_output("tx_done_line", 32'(tx_a), 32'd1);
        tick();
        check_output("tx_after_done", 32'(host_a.done), 32'd0);
        check_output("tx_after_ready", 32'(host_a.ready), 32'd1);

        // RX at DIV=1 of bits 1,1,0,0,1,0,1,0.
        rx_bits = 8'b1100_1010;
        host_b.mode = MODE_RX; host_b.data_in = 8'hFF; host_b.start = 1'b1;
        tick();
        host_b.start = 1'b0;
        check_output("rx_prep_clr_n", 32'(clr_n_b), 32'd0);
        check_output("rx_prep_shift", 32'(shift_b), 32'd0);
        check_output("rx_prep_q", 32'(q_b), 32'd0);
        for (int c = 2; c <= 9; c++) begin
            tick();
            rx_b = rx_bits[7 - (c - 2)];
            check_output($sformatf("rx_nodone_c%0d", c), 32'(host_b.done), 32'd0);
        end
        tick();
        rx_b = 1'b0;
        check_output("rx_done", 32'(host_b.done), 32'd1);
        check_output("rx_data", 32'(host_b.data_out), 32'hCA);
        tick();
        check_output("rx_data_hold", 32'(host_b.data_out), 32'hCA);
        check_output("rx_idle_ready", 32'(host_b.ready), 32'd1);

        // start held through a transfer and its DONE: the second transfer begins only from IDLE.
        host_b.mode = MODE_TX; host_b.data_in = 8'h3C; host_b.start = 1'b1;
        for (int c = 1; c <= 21; c++) begin
            tick();
            if (c == 12) host_b.start = 1'b0;
            check_output($sformatf("hold_done_c%0d", c), 32'(host_b.done), 32'((c == 10) || (c == 21)));
            check_output($sformatf("hold_busy_c%0d", c), 32'(host_b.busy), 32'((c != 10) && (c != 11) && (c != 21)));
        end
        tick();
        check_output("hold_idle", 32'(host_b.ready), 32'd1);

        // Reset in the middle of a TX transfer, after three bits.
        host_a.mode = MODE_TX; host_a.data_in = 8'hA5; host_a.start = 1'b1;
        tick();
        host_a.start = 1'b0;
        for (int c = 2; c <= 8; c++) tick();
        check_output("abort_pre_busy", 32'(host_a.busy), 32'd1);
        clear = 1'b0;
        tick();
        check_output("abort_ready", 32'(host_a.ready), 32'd1);
        check_output("abort_busy", 32'(host_a.busy), 32'd0);
        check_output("abort_tx", 32'(tx_a), 32'd1);
        check_output("abort_q", 32'(q_a), 32'd0);
        check_output("abort_done", 32'(host_a.done), 32'd0);
        clear = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_output($sformatf("abort_nodone_%0d", c), 32'(host_a.done), 32'd0);
        end

        // start and reset together: reset wins and no PREP follows.
        host_a.start = 1'b1;
        clear = 1'b0;
        tick();
        check_output("both_ready", 32'(host_a.ready), 32'd1);
        check_output("both_busy", 32'(host_a.busy), 32'd0);
        host_a.start = 1'b0;
        clear = 1'b1;
        tick();
        check_output("both_after_busy", 32'(host_a.busy), 32'd0);
        check_output("both_after_ready", 32'(host_a.ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
